// File: rtl/irrigation_scheduler_if.sv
// Sensor and actuator bundle of the irrigation scheduler.
// All signals are plain levels: there is no valid/ready handshake. Sensors are
// sampled every cycle and actuator outputs hold their value until they change.
// Optional port run_count exists only when CYCLE_COUNT_EN is defined.
interface irrigation_scheduler_if;
    logic       H;
    logic       M;
    logic       L;
    logic       Us;
    logic       Ua;
    logic       Key_Ad;
    logic       Bs;
    logic       Vs;
    logic       Ve;
    logic       Ad;
    logic       Al;
    logic       E;
    logic [2:0] state;
`ifdef CYCLE_COUNT_EN
    logic [7:0] run_count;
`endif

    // Scheduler side: reads sensors, drives actuators and the debug state.
    modport slave (
        input  H, M, L, Us, Ua, Key_Ad,
`ifdef CYCLE_COUNT_EN
        output run_count,
`endif
        output Bs, Vs, Ve, Ad, Al, E, state
    );

    // Environment side: drives sensors, observes actuators.
    modport master (
        output H, M, L, Us, Ua, Key_Ad,
`ifdef CYCLE_COUNT_EN
        input  run_count,
`endif
        input  Bs, Vs, Ve, Ad, Al, E, state
    );
endinterface

// File: rtl/irrigation_scheduler.sv
// Irrigation scheduler: synchronises and debounces the tank level sensors,
// drives the fill valve with hysteresis and shares the tank between sprinkler,
// drip line and agrodefensive dosing with a tick-timed FSM.
// Optional macro CYCLE_COUNT_EN adds a saturating run_count of completed runs.
module irrigation_scheduler #(
    parameter int CLK_DIV   = 50000,
    parameter int DEBOUNCE  = 4,
    parameter int MIN_RUN   = 10,
    parameter int MAX_RUN   = 60,
    parameter int DOSE_TIME = 5
) (
    input  logic                   clock,
    input  logic                   reset_n,
    irrigation_scheduler_if.slave  bus
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int TW = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SPRINKLE = 3'd1,
        ST_DRIP     = 3'd2,
        ST_DOSE     = 3'd3,
        ST_REST     = 3'd4,
        ST_HOLD     = 3'd5
    } state_e;

    logic [5:0]    sync1_q, sync2_q;
    logic [PW-1:0] pre_q;
    logic          tick;
    logic [2:0]    cand_q, level_q;
    logic [DW-1:0] db_cnt_q;
    logic          al_q, e_q, ve_q;
    logic          bs_q, vs_q, ad_q;
    logic          dose_q, dose_d, dose_clr;
    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;

    logic [2:0] lvl_s;
    logic       us_s, ua_s, key_s;
    logic       lvl_empty, lvl_low, lvl_mid, lvl_full, lvl_err;
    logic       spr_req, drip_req, run_done;

    assign lvl_s = sync2_q[5:3];
    assign us_s  = sync2_q[2];
    assign ua_s  = sync2_q[1];
    assign key_s = sync2_q[0];

    // Two-flop synchronisers for every raw sensor and the dose key.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {bus.H, bus.M, bus.L, bus.Us, bus.Ua, bus.Key_Ad};
            sync2_q <= sync1_q;
        end
    end

    // Prescaler producing a one-cycle tick every CLK_DIV cycles.
    assign tick = (pre_q == PW'(CLK_DIV - 1));
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) pre_q <= '0;
        else          pre_q <= tick ? '0 : pre_q + 1'b1;
    end

    // Level debounce: a pattern is accepted after DEBOUNCE stable ticks.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cand_q   <= '0;
            db_cnt_q <= '0;
            level_q  <= '0;
        end else begin
            if (lvl_s != cand_q) begin
                cand_q   <= lvl_s;
                db_cnt_q <= '0;
            end else if (tick && db_cnt_q != DW'(DEBOUNCE)) begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
            if (db_cnt_q == DW'(DEBOUNCE)) level_q <= cand_q;
        end
    end

    assign lvl_empty = (level_q == 3'b000);
    assign lvl_low   = (level_q == 3'b001);
    assign lvl_mid   = (level_q == 3'b011);
    assign lvl_full  = (level_q == 3'b111);
    assign lvl_err   = ~(lvl_empty | lvl_low | lvl_mid | lvl_full);

    // Alarm, sensor error and fill valve with hysteresis (mid holds Ve).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            al_q <= 1'b1;
            e_q  <= 1'b0;
            ve_q <= 1'b0;
        end else begin
            al_q <= lvl_empty | lvl_err;
            e_q  <= lvl_err;
            if (lvl_empty | lvl_low)     ve_q <= 1'b1;
            else if (lvl_full | lvl_err) ve_q <= 1'b0;
        end
    end

    assign spr_req  = ~us_s & ~ua_s;
    assign drip_req = ~us_s & ua_s;
    assign run_done = (us_s && timer_q >= TW'(MIN_RUN)) || (timer_q == TW'(MAX_RUN));

    // Next-state logic; the alarm always pre-empts a timed exit.
    always_comb begin
        state_d  = state_q;
        dose_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (al_q)          state_d = ST_HOLD;
                else if (spr_req)  state_d = ST_SPRINKLE;
                else if (drip_req) state_d = ST_DRIP;
            end
            ST_SPRINKLE: begin
                if (al_q)          state_d = ST_HOLD;
                else if (run_done) state_d = dose_q ? ST_DOSE : ST_REST;
            end
            ST_DRIP: begin
                if (al_q)          state_d = ST_HOLD;
                else if (run_done) state_d = ST_REST;
            end
            ST_DOSE: begin
                if (al_q) begin
                    state_d = ST_HOLD;
                end else if (timer_q == TW'(DOSE_TIME)) begin
                    state_d  = ST_REST;
                    dose_clr = 1'b1;
                end
            end
            ST_REST: begin
                if (timer_q == TW'(MIN_RUN)) state_d = ST_IDLE;
            end
            ST_HOLD: begin
                if (!al_q) state_d = ST_REST;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State timer restarts on every state change and counts ticks (saturating).
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q)           timer_d = '0;
        else if (tick && timer_q != '1)   timer_d = timer_q + 1'b1;
    end

    // Dose request latch: a new request wins over the clear on leaving DOSE.
    always_comb begin
        dose_d = dose_q;
        if (key_s)         dose_d = 1'b1;
        else if (dose_clr) dose_d = 1'b0;
    end

    // FSM, timer, dose latch and valve registers (valves lag the state by one cycle).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            dose_q  <= 1'b0;
            bs_q    <= 1'b0;
            vs_q    <= 1'b0;
            ad_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            dose_q  <= dose_d;
            bs_q    <= (state_q == ST_SPRINKLE) || (state_q == ST_DOSE);
            vs_q    <= (state_q == ST_DRIP);
            ad_q    <= (state_q == ST_DOSE);
        end
    end

`ifdef CYCLE_COUNT_EN
    logic [7:0] run_count_q;
    logic       normal_exit;

    assign normal_exit = ((state_q == ST_SPRINKLE) || (state_q == ST_DRIP)) &&
                         (state_d != state_q) && (state_d != ST_HOLD);

    // Completed-run counter, saturating at 255; alarm aborts are not counted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                             run_count_q <= '0;
        else if (normal_exit && run_count_q != '1) run_count_q <= run_count_q + 1'b1;
    end

    assign bus.run_count = run_count_q;
`endif

    assign bus.Bs    = bs_q;
    assign bus.Vs    = vs_q;
    assign bus.Ve    = ve_q;
    assign bus.Ad    = ad_q;
    assign bus.Al    = al_q;
    assign bus.E     = e_q;
    assign bus.state = state_q;
endmodule

// File: doc/irrigation_scheduler.md
Name: irrigation_scheduler

Overview:
- Sequential controller for the tank and irrigation datapath.
- Debounces the H/M/L tank level sensors and derives Al and E from the debounced level.
- Runs the fill valve Ve with hysteresis.
- Shares the tank between the sprinkler (Bs), the drip line (Vs) and agrodefensive dosing (Ad) using a timed state machine, with minimum and maximum run times and a rest interval after each run.
- Sits between the raw sensor inputs and the actuator and display logic.

Parameters:
- CLK_DIV, 50000: clock cycles per tick; all timers count ticks.
- DEBOUNCE, 4: ticks a level pattern must stay stable before it is accepted.
- MIN_RUN, 10: minimum run time in ticks; also the rest time after a run.
- MAX_RUN, 60: maximum sprinkle or drip run time in ticks.
- DOSE_TIME, 5: agrodefensive dose length in ticks.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- H  in  1  high-level sensor
- M  in  1  mid-level sensor
- L  in  1  low-level sensor
- Us  in  1  soil humid
- Ua  in  1  air humid
- Key_Ad  in  1  agrodefensive request, pulse or level
- Bs  out  1  sprinkler valve
- Vs  out  1  drip valve
- Ve  out  1  tank fill valve
- Ad  out  1  agrodefensive injector
- Al  out  1  alarm
- E  out  1  level sensor error
- state  out  3  FSM state code

Behaviour:
- Reset, asynchronous while reset_n=0:
  - Bs, Vs, Ve, Ad, E = 0; Al = 1; state = IDLE (0).
  - Debounced level = 000; prescaler, timers and dose latch = 0.
- Sensor inputs: all raw inputs pass through 2-FF synchronisers.
- Tick: one-cycle pulse every CLK_DIV cycles.
- Level debounce:
  - A candidate {H,M,L} is accepted once it has been unchanged for DEBOUNCE consecutive ticks.
  - Any change in the pattern restarts the count.
- Level decode of the debounced {H,M,L}:
  - 000 = empty, 001 = low, 011 = mid, 111 = full.
  - Any other pattern = error.
- Al and E (registered):
  - E = error.
  - Al = empty OR error.
- Fill valve Ve (registered hysteresis):
  - Set when the level is empty or low.
  - Cleared when the level is full or error.
  - Held unchanged at mid.
- Demands:
  - spr_req = ~Us & ~Ua.
  - drip_req = ~Us & Ua.
- Dose latch: set by Key_Ad=1 on any cycle; cleared only on exit from DOSE.
- FSM states: IDLE=0, SPRINKLE=1, DRIP=2, DOSE=3, REST=4, HOLD=5.
  - The state timer clears on every state entry and increments on each tick.
- IDLE:
  - Al → HOLD.
  - Else spr_req → SPRINKLE.
  - Else drip_req → DRIP.
  - Sprinkle wins if both demands are active.
- SPRINKLE (Bs=1):
  - Al → HOLD immediately.
  - Exits when (Us=1 and timer ≥ MIN_RUN) or timer = MAX_RUN.
  - On exit, goes to DOSE if the dose latch is set, else to REST.
- DRIP (Vs=1):
  - Al → HOLD immediately.
  - Exits under the same conditions as SPRINKLE; always goes to REST.
- DOSE (Bs=1, Ad=1):
  - Al → HOLD, and the dose latch is kept.
  - Timer = DOSE_TIME → REST.
- REST: all valves off; timer = MIN_RUN → IDLE.
- HOLD: all valves off; goes to REST on the first cycle with Al=0.
- Outputs:
  - Bs, Vs and Ad are registered and follow the state with one cycle of latency.
  - Bs and Vs are never 1 together.
  - Ad=1 only while Bs=1.
- Simultaneous events: an Al rise on the same cycle as a timer exit goes to HOLD.
- Reset mid-run clears everything, including the dose latch.

Optional Feature:
- Macro: CYCLE_COUNT_EN.
- When defined:
  - Adds output run_count [7:0], reset 0.
  - Increments on each normal exit from SPRINKLE or DRIP, i.e. not an Al abort.
  - Saturates at 255.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Test parameters for all scenarios: CLK_DIV=4, DEBOUNCE=2, MIN_RUN=3, MAX_RUN=8, DOSE_TIME=2.
- Level glitch:
  - Stimulus: level 111 held for 1 tick, then 001.
  - Response: debounced level never becomes full; Ve=1 and Al=0 once 001 has been accepted.
- Fill hysteresis:
  - Stimulus: level ramps 001 → 011 → 111 → 011.
  - Response: Ve stays 1 through mid, goes 0 at full, and stays 0 at the following mid.
- Sprinkle run with early humidity:
  - Stimulus: level 011, Us=0, Ua=0; Us=1 at tick 1.
  - Response: Bs=1 for exactly 3 ticks, then REST for 3 ticks, then IDLE; Vs=0 throughout.
- Maximum run and dose:
  - Stimulus: Us=0, Ua=0 held; one-cycle Key_Ad pulse during SPRINKLE.
  - Response: SPRINKLE lasts 8 ticks, then DOSE with Bs=1, Ad=1 for 2 ticks, then REST; the dose latch clears.
- Alarm abort:
  - Stimulus: DRIP active (Ua=1, Us=0), then level forced to 101.
  - Response: after debounce, E=1, Al=1, Vs=0 on the next cycle, state=5; restoring 011 gives REST and then IDLE.
- Asynchronous reset mid-run:
  - Stimulus: reset_n pulled low during SPRINKLE.
  - Response: Bs=0 and state=0 immediately, without waiting for a clock edge; with CYCLE_COUNT_EN defined, run_count=0.
